// File: rtl/gcu_out_serializer.sv
// Output serializer for the GELU compute unit.
// Captures a vector of NUM_GELU Q48.16 lanes, requantizes each lane to
// Q8.8 (round half toward +inf, then saturate), and emits the result as
// BEATS beats of LANES_PER_BEAT lanes over a valid/ready stream. It also
// keeps a saturating count of clipped lanes.
module gcu_out_serializer #(
  parameter int Q              = 16,
  parameter int W              = 64,
  parameter int NUM_GELU       = 32,
  parameter int OUT_W          = 16,
  parameter int OUT_Q          = 8,
  parameter int LANES_PER_BEAT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     in_data [NUM_GELU],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data [LANES_PER_BEAT],
  output logic                    out_last,
  input  logic                    sat_clear,
  output logic [15:0]             sat_count
);

  localparam int BEATS = NUM_GELU / LANES_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SH    = Q - OUT_Q;
  localparam int IW    = W + 1;
  localparam int NW    = $clog2(NUM_GELU + 1);

  localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
  localparam logic signed [IW-1:0] RND       = IW'(1) << (SH - 1);
  localparam logic signed [IW-1:0] SAT_MAX   = IW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN   = -SAT_MAX - 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state, state_d;
  logic [BW-1:0]           beat, beat_d;
  logic                    accept_in;
  logic                    accept_out;

  logic signed [OUT_W-1:0] lane_buf [BEATS][LANES_PER_BEAT];
  logic signed [OUT_W-1:0] q_lane   [NUM_GELU];
  logic [NUM_GELU-1:0]     q_sat;
  logic [NW-1:0]           sat_sum;
  logic [16:0]             sat_acc;

  // One lane: round, shift, clip. Returns {clipped, value}; the sum is done
  // one bit wider than the lane so the rounding add cannot overflow.
  function automatic logic [OUT_W:0] requant(input logic signed [W-1:0] x);
    logic signed [IW-1:0] t;
    t = (IW'(x) + RND) >>> SH;
    if (t > SAT_MAX)
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (t < SAT_MIN)
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    else
      return {1'b0, t[OUT_W-1:0]};
  endfunction

  assign out_valid  = (state == SEND);
  assign out_last   = (state == SEND) && (beat == LAST_BEAT);
  assign in_ready   = (state == IDLE) || ((beat == LAST_BEAT) && out_ready);
  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;

  // Requantize every incoming lane and total the clipped lanes.
  always_comb begin
    sat_sum = '0;
    for (int unsigned i = 0; i < NUM_GELU; i++) begin
      {q_sat[i], q_lane[i]} = requant(in_data[i]);
      sat_sum = sat_sum + NW'(q_sat[i]);
    end
  end

  // Current beat comes straight from the buffer; beat is left untouched on
  // return to IDLE, so out_data keeps showing the last beat sent.
  always_comb begin
    for (int unsigned j = 0; j < LANES_PER_BEAT; j++) begin
      out_data[j] = lane_buf[beat][j];
    end
  end

  // Next-state and beat-index logic.
  always_comb begin
    state_d = state;
    beat_d  = beat;
    if (accept_in) begin
      state_d = SEND;
      beat_d  = '0;
    end else if (accept_out) begin
      if (beat == LAST_BEAT)
        state_d = IDLE;
      else
        beat_d = beat + 1'b1;
    end
  end

  // State and beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
    end
  end

  // Lane buffer, loaded with the whole requantized vector on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < BEATS; b++)
        for (int unsigned j = 0; j < LANES_PER_BEAT; j++)
          lane_buf[b][j] <= '0;
    end else if (accept_in) begin
      for (int unsigned b = 0; b < BEATS; b++)
        for (int unsigned j = 0; j < LANES_PER_BEAT; j++)
          lane_buf[b][j] <= q_lane[b*LANES_PER_BEAT + j];
    end
  end

  // Clear takes effect before the new capture's total is added.
  always_comb begin
    sat_acc = (sat_clear ? 17'd0 : {1'b0, sat_count}) + 17'(sat_sum);
  end

  // Saturating clip counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (accept_in)
      sat_count <= sat_acc[16] ? '1 : sat_acc[15:0];
    else if (sat_clear)
      sat_count <= '0;
  end

endmodule

// File: tb/tb_gcu_out_serializer.sv
`timescale 1ns/1ps
// Scoreboard bench for gcu_out_serializer: a driver pushes expected beats
// from a behavioural requantization model, a monitor pops and compares each
// accepted output beat.
module tb_gcu_out_serializer;

  localparam int Q = 16, W = 64, NG = 32, OW = 16, OQ = 8, LPB = 8;
  localparam int BEATS = NG / LPB;
  localparam int SH = Q - OQ;

  typedef logic signed [W-1:0] vec_t [NG];
  typedef struct {
    logic [LPB*OW-1:0] data;
    bit                last;
  } beat_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_data [NG];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data [LPB];
  logic                 out_last;
  logic                 sat_clear;
  logic [15:0]          sat_count;

  int          total = 0;
  int          bad = 0;
  beat_t       sb[$];
  int unsigned sat_exp = 0;
  int          beats_acc = 0;
  int          rdy_mode = 0;
  bit          stall_prev = 0;
  logic [LPB*OW-1:0] prev_data;
  logic        prev_last;
  logic signed [W-1:0] bnd [6];

  gcu_out_serializer #(
    .Q(Q), .W(W), .NUM_GELU(NG), .OUT_W(OW), .OUT_Q(OQ), .LANES_PER_BEAT(LPB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sat_clear(sat_clear), .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: floor((x + 2^(SH-1)) / 2^SH), clipped to the signed OW range.
  function automatic int push_model(input vec_t v);
    int    n;
    beat_t e;
    n = 0;
    for (int b = 0; b < BEATS; b++) begin
      e.data = '0;
      for (int j = 0; j < LPB; j++) begin
        logic signed [W+7:0] t;
        logic [OW-1:0]       r;
        t = v[b*LPB + j];
        t = (t + 2**(SH-1)) >>> SH;
        if (t > 2**(OW-1) - 1) begin
          r = 16'h7FFF; n++;
        end else if (t < -(2**(OW-1))) begin
          r = 16'h8000; n++;
        end else begin
          r = t[OW-1:0];
        end
        e.data[j*OW +: OW] = r;
      end
      e.last = (b == BEATS - 1);
      sb.push_back(e);
    end
    return n;
  endfunction

  function automatic logic signed [W-1:0] rand_lane();
    logic signed [W-1:0] v;
    if ($urandom_range(0, 7) == 0) return bnd[$urandom_range(0, 5)];
    v = {$urandom, $urandom};
    v = v >>> $urandom_range(20, 63);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NG; i++) v[i] = rand_lane();
    return v;
  endfunction

  function automatic vec_t zero_vec();
    vec_t v;
    for (int i = 0; i < NG; i++) v[i] = '0;
    return v;
  endfunction

  task automatic send(input vec_t v, input bit clr);
    int n;
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v;
    sat_clear = clr;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      fail("accept_timeout");
      in_valid  = 1'b0;
      sat_clear = 1'b0;
      return;
    end
    n = push_model(v);
    if (clr) sat_exp = n;
    else sat_exp = (sat_exp + n > 65535) ? 65535 : sat_exp + n;
    @(posedge clk);
    #1;
    chk("sat_count", sat_count, sat_exp);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    sat_clear = 1'b0;
  endtask

  task automatic clear_sat();
    @(negedge clk);
    in_valid  = 1'b0;
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_exp = 0;
    chk("sat_clear", sat_count, 16'h0000);
    @(negedge clk);
    sat_clear = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #4;
      if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) fail("drain_timeout");
  endtask

  // Random backpressure source.
  always @(negedge clk) begin
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every accepted beat, checks hold under stall and in_ready.
  always @(negedge clk) begin
    logic [LPB*OW-1:0] act;
    beat_t e;
    #2;
    for (int j = 0; j < LPB; j++) act[j*OW +: OW] = out_data[j];
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_data", act, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid) begin
        chk("in_ready_busy", in_ready,
            (sb.size() > 0) && sb[0].last && out_ready);
        if (out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat actual=%0h required=none", act);
          end else begin
            e = sb.pop_front();
            chk("beat_data", act, e.data);
            chk("beat_last", out_last, e.last);
            beats_acc++;
          end
        end
      end else begin
        chk("in_ready_idle", in_ready, 1'b1);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = act;
      prev_last  = out_last;
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    vec_t v, a, b, c;
    logic [LPB*OW-1:0] rst_data;
    int   base, f, run, nl;
    bit   vs [40];
    bit   ls [40];
    logic [11:0] lastpat;

    bnd[0] = 64'sd8388479;   // 32767*256+127 -> 32767
    bnd[1] = 64'sd8388480;   // rounds to 32768 -> clips
    bnd[2] = -64'sd8388736;  // exactly -32768 after rounding
    bnd[3] = -64'sd8388737;  // -32769 -> clips
    bnd[4] = 64'sd128;       // half rounds up to 1
    bnd[5] = -64'sd128;      // half rounds toward +inf to 0

    rst_n = 1'b0; in_valid = 1'b0; sat_clear = 1'b0; out_ready = 1'b1;
    in_data = zero_vec();
    repeat (3) @(negedge clk);
    #1;
    for (int j = 0; j < LPB; j++) rst_data[j*OW +: OW] = out_data[j];
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sat_count", sat_count, 16'h0000);
    chk("rst_out_data", rst_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rounding vector.
    v = zero_vec();
    v[0] = 64'sh10000; v[1] = 64'sh180; v[2] = -64'sh180; v[3] = 64'sh7F;
    send(v, 1'b0);
    chk("round_l0", $unsigned(out_data[0]), 16'h0100);
    chk("round_l1", $unsigned(out_data[1]), 16'h0002);
    chk("round_l2", $unsigned(out_data[2]), 16'hFFFF);
    chk("round_l3", $unsigned(out_data[3]), 16'h0000);
    idle();
    drain();

    // Saturation vector.
    clear_sat();
    v = zero_vec();
    v[0] = 64'sh0000_0100_0000_0000;
    v[1] = -64'sh0000_0100_0000_0000;
    send(v, 1'b0);
    chk("sat_l0", $unsigned(out_data[0]), 16'h7FFF);
    chk("sat_l1", $unsigned(out_data[1]), 16'h8000);
    chk("sat_two", sat_count, 16'd2);
    idle();
    drain();
    clear_sat();

    // Backpressure at beat 2.
    rdy_mode = 2;
    base = beats_acc;
    send(rand_vec(), 1'b0);
    idle();
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    drain();
    chk("bp_beats", beats_acc - base, 4);

    // Back-to-back vectors.
    rdy_mode = 0;
    a = rand_vec(); b = rand_vec(); c = rand_vec();
    fork
      begin
        send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); idle();
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          #3;
          vs[k] = out_valid;
          ls[k] = out_last;
        end
      end
    join
    f = -1; nl = 0;
    for (int k = 0; k < 40; k++) begin
      if (vs[k] && f < 0) f = k;
      if (ls[k]) nl++;
    end
    if (f < 0 || f > 27) begin
      fail("b2b_start");
    end else begin
      run = 0;
      while (f + run < 40 && vs[f + run]) run++;
      for (int i = 0; i < 12; i++) lastpat[i] = ls[f + i];
      chk("b2b_run", run, 12);
      chk("b2b_lasts", lastpat, 12'b1000_1000_1000);
      chk("b2b_nlast", nl, 3);
    end
    drain();

    // Random traffic with random backpressure and occasional clears.
    rdy_mode = 1;
    for (int it = 0; it < 60; it++) begin
      send(rand_vec(), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    drain();
    @(negedge clk);
    rdy_mode  = 0;
    out_ready = 1'b1;

    // Counter clamp at 16'hFFFF.
    clear_sat();
    for (int i = 0; i < NG; i++)
      v[i] = (i % 2 == 0) ? 64'sh0000_0100_0000_0000 : -64'sh0000_0100_0000_0000;
    for (int n = 0; n < 2050; n++) send(v, 1'b0);
    idle();
    drain();
    chk("sat_clamp", sat_count, 16'hFFFF);

    // Reset during beat 1.
    send(rand_vec(), 1'b0);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_last", out_last, 1'b0);
    chk("rst_mid_sat", sat_count, 16'h0000);
    sb.delete();
    sat_exp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_in_ready", in_ready, 1'b1);
    send(rand_vec(), 1'b0);
    chk("rst_new_first_last", out_last, 1'b0);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcu_out_serializer.md
GCU_OUT_SERIALIZER -- requirements
Module: gcu_out_serializer

Interface
REQ-001 SHALL have parameter Q, default 16, fractional bits of the input lanes (Q48.16).
REQ-002 SHALL have parameter W, default 64, input lane width.
REQ-003 SHALL have parameter NUM_GELU, default 32, input lanes per vector.
REQ-004 SHALL have parameter OUT_W, default 16, output lane width.
REQ-005 SHALL have parameter OUT_Q, default 8, output fractional bits (Q8.8).
REQ-006 SHALL have parameter LANES_PER_BEAT, default 8, output lanes per beat; NUM_GELU is a multiple of it.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port in_valid, input, 1, an input vector is present.
REQ-010 SHALL have port in_ready, output, 1, the block accepts an input vector this cycle.
REQ-011 SHALL have port in_data, input, signed [W-1:0] x NUM_GELU, the vector of GELU outputs (Q48.16).
REQ-012 SHALL have port out_valid, output, 1, an output beat is present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-014 SHALL have port out_data, output, signed [OUT_W-1:0] x LANES_PER_BEAT, the requantized lanes.
REQ-015 SHALL have port out_last, output, 1, marks the final beat of a vector.
REQ-016 SHALL have port sat_clear, input, 1, synchronous clear of sat_count.
REQ-017 SHALL have port sat_count, output, 16, saturating count of lanes clipped during requantization.

Function
REQ-018 SHALL implement FSM states IDLE and SEND; BEATS = NUM_GELU/LANES_PER_BEAT (default 4).
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in SEND only when beat == BEATS-1 and out_ready == 1; otherwise 0.
REQ-020 On in_valid && in_ready the block SHALL register all NUM_GELU requantized lanes, set beat = 0, and enter or stay in SEND.
REQ-021 Requantization per lane SHALL add 2^(Q-OUT_Q-1), arithmetic-shift right by Q-OUT_Q (round half toward +inf), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 Intermediate arithmetic SHALL be at least W+1 bits, with no overflow before saturation.
REQ-023 In SEND, out_valid SHALL be 1, and out_data SHALL equal buffered lanes [beat*LANES_PER_BEAT +: LANES_PER_BEAT], with lane 0 of the beat at the lowest index.
REQ-024 out_last SHALL be 1 exactly when out_valid is 1 and beat == BEATS-1.
REQ-025 On out_valid && out_ready with beat < BEATS-1, beat SHALL increment.
REQ-026 On acceptance of the last beat, the block SHALL return to IDLE unless a new vector is accepted in the same cycle (per REQ-020), giving back-to-back vectors with no bubble.
REQ-027 While out_valid is 1 and out_ready is 0, out_data, out_last and beat SHALL hold stable.
REQ-028 First-beat latency SHALL be 1 cycle after input acceptance; one vector SHALL occupy exactly BEATS accepted beats.
REQ-029 For each captured lane that saturates, sat_count SHALL increase by 1; multiple lanes in one capture SHALL add their total, clamping at 16'hFFFF.
REQ-030 If sat_clear and a capture occur together, sat_count SHALL become the new capture's saturation total.
REQ-031 out_valid SHALL be 0 in IDLE; out_data SHALL then hold its last value.

Reset
REQ-032 While rst_n == 0, the block SHALL force state = IDLE, beat = 0, out_valid = 0, out_last = 0, out_data = 0, lane buffer = 0 and sat_count = 0, asynchronously.
REQ-033 Reset asserted mid-SEND SHALL discard the remaining beats; after release, in_ready SHALL be 1 on the first cycle.

Verification
REQ-034 Rounding: lanes 0x10000, 0x180, -0x180, 0x7F with out_ready = 1 -> beat 0 lanes 0x0100, 0x0002, 0xFFFF, 0x0000; out_last only on beat 3; in_ready low during beats 0-2.
REQ-035 Saturation: lane 0 = 0x0000_0100_0000_0000, lane 1 = -0x0000_0100_0000_0000, others 0 -> 0x7FFF and 0x8000; sat_count = 2; sat_clear pulse -> 0.
REQ-036 Backpressure: out_ready low for 5 cycles at beat 2 -> out_data and out_last stable; after out_ready rises, beats 2 and 3 complete; total 4 accepted beats.
REQ-037 Back-to-back: in_valid held high with 3 distinct vectors and out_ready = 1 -> 12 consecutive out_valid cycles, no bubble, out_last at cycles 4, 8 and 12.
REQ-038 Reset during beat 1 -> out_valid = 0 immediately, sat_count = 0; a new vector after release emits from beat 0.
